// File: rtl/screensaver_pkg.sv
// Shared types and helpers for the multi-box screensaver renderer.
// Box state layout, update FSM states, reset-value and colour-cycling helpers.
package screensaver_pkg;

  localparam int DEFAULT_SCREEN_WIDTH  = 640;
  localparam int DEFAULT_SCREEN_HEIGHT = 480;

  typedef struct packed {
    logic signed [10:0] x;
    logic signed [9:0]  y;
    logic signed [3:0]  xv;
    logic signed [3:0]  yv;
    logic [2:0]         color;
  } box_state_t;

  typedef enum logic {IDLE, STEP} fsm_state_t;

  // Colour cycles 1..7 and never lands on 0 (black).
  function automatic logic [2:0] next_color(input logic [2:0] c);
    return (c == 3'd7) ? 3'd1 : c + 3'd1;
  endfunction

  function automatic box_state_t reset_box(input int i);
    box_state_t b;
    b.x     = 11'(20 + (130 * i) % 576);
    b.y     = 10'(10 + (90 * i) % 432);
    b.xv    = (i % 2 == 0) ? 4'(1 + i % 3) : 4'(-(1 + i % 3));
    b.yv    = (i % 2 == 0) ? 4'sd1 : -4'sd2;
    b.color = 3'(1 + i % 7);
    return b;
  endfunction

endpackage

// File: rtl/multi_box_renderer_if.sv
// Pixel-stream interface between the VGA timing generator and the renderer.
interface multi_box_renderer_if;
  logic       frame_tick;
  logic       visible;
  logic [9:0] position_x;
  logic [8:0] position_y;
  logic [3:0] r;
  logic [3:0] g;
  logic [3:0] b;
  logic       update_busy;

  modport master (output frame_tick, visible, position_x, position_y,
                  input  r, g, b, update_busy);
  modport slave  (input  frame_tick, visible, position_x, position_y,
                  output r, g, b, update_busy);
endinterface

// File: rtl/box_step.sv
// Combinational one-frame advance of a single box: move, bounce off the
// screen edges (clamped into range) and cycle colour on any bounce.
import screensaver_pkg::*;

module box_step #(
  parameter int XL = 576,
  parameter int YL = 432
) (
  input  box_state_t box_in,
  output box_state_t box_out
);

  localparam logic signed [10:0] XL_S = 11'(XL);
  localparam logic signed [9:0]  YL_S = 10'(YL);

  logic signed [10:0] tx;
  logic signed [9:0]  ty;
  logic               hx;
  logic               hy;

  always_comb begin
    box_out = box_in;
    tx = box_in.x + {{7{box_in.xv[3]}}, box_in.xv};
    ty = box_in.y + {{6{box_in.yv[3]}}, box_in.yv};
    hx = (tx < 11'sd0) || (tx >= XL_S);
    hy = (ty < 10'sd0) || (ty >= YL_S);

    if (tx < 11'sd0)      box_out.x = '0;
    else if (tx > XL_S)   box_out.x = XL_S;
    else                  box_out.x = tx;

    if (ty < 10'sd0)      box_out.y = '0;
    else if (ty > YL_S)   box_out.y = YL_S;
    else                  box_out.y = ty;

    if (hx) box_out.xv = -box_in.xv;
    if (hy) box_out.yv = -box_in.yv;
    // A corner hit still advances the colour only once.
    if (hx || hy) box_out.color = next_color(box_in.color);
  end

endmodule

// File: rtl/multi_box_renderer.sv
// Animates N_BOXES bouncing boxes and renders registered 4-bit RGB per pixel.
// Optional outline on the winning box when BOX_BORDER_EN is defined.
import screensaver_pkg::*;

module multi_box_renderer #(
  parameter int N_BOXES       = 4,
  parameter int SCREEN_WIDTH  = DEFAULT_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEFAULT_SCREEN_HEIGHT,
  parameter int BOX_WIDTH     = 64,
  parameter int BOX_HEIGHT    = 48
) (
  input logic                  clk,
  input logic                  rst,
  multi_box_renderer_if.slave  vga
);

  localparam int IDX_W = (N_BOXES > 1) ? $clog2(N_BOXES) : 1;

  fsm_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  box_state_t       box_q [N_BOXES];
  box_state_t       box_d [N_BOXES];
  box_state_t       step_out;
  logic [3:0]       r_q, r_d, g_q, g_d, b_q, b_d;

  logic [11:0] px, py, bx, by;
  logic        win_found;
  logic [2:0]  win_color;
`ifdef BOX_BORDER_EN
  logic        win_edge;
`endif

  box_step #(
    .XL(SCREEN_WIDTH - BOX_WIDTH),
    .YL(SCREEN_HEIGHT - BOX_HEIGHT)
  ) u_step (
    .box_in (box_q[idx_q]),
    .box_out(step_out)
  );

  // Frame update: one box per cycle through the shared step unit; ticks seen while stepping are dropped.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    box_d   = box_q;
    case (state_q)
      IDLE: if (vga.frame_tick) begin
        state_d = STEP;
        idx_d   = '0;
      end
      STEP: begin
        box_d[idx_q] = step_out;
        if (idx_q == IDX_W'(N_BOXES - 1)) state_d = IDLE;
        else                               idx_d   = idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan from the highest index down so the lowest-index hit wins.
  always_comb begin
    px        = {2'b00, vga.position_x};
    py        = {3'b000, vga.position_y};
    bx        = '0;
    by        = '0;
    win_found = 1'b0;
    win_color = '0;
`ifdef BOX_BORDER_EN
    win_edge  = 1'b0;
`endif
    for (int i = N_BOXES - 1; i >= 0; i--) begin
      bx = {1'b0, box_q[i].x};
      by = {2'b00, box_q[i].y};
      if (px >= bx && px < bx + 12'(BOX_WIDTH) && py >= by && py < by + 12'(BOX_HEIGHT)) begin
        win_found = 1'b1;
        win_color = box_q[i].color;
`ifdef BOX_BORDER_EN
        win_edge  = (px == bx) || (px == bx + 12'(BOX_WIDTH - 1)) ||
                    (py == by) || (py == by + 12'(BOX_HEIGHT - 1));
`endif
      end
    end

    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (vga.visible && win_found) begin
`ifdef BOX_BORDER_EN
      if (win_edge) begin
        r_d = 4'hF;
        g_d = 4'hF;
        b_d = 4'hF;
      end else begin
        r_d = {4{win_color[0]}};
        g_d = {4{win_color[1]}};
        b_d = {4{win_color[2]}};
      end
`else
      r_d = {4{win_color[0]}};
      g_d = {4{win_color[1]}};
      b_d = {4{win_color[2]}};
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      for (int i = 0; i < N_BOXES; i++) box_q[i] <= reset_box(i);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      box_q   <= box_d;
    end
  end

  assign vga.r           = r_q;
  assign vga.g           = g_q;
  assign vga.b           = b_q;
  assign vga.update_busy = (state_q == STEP);

endmodule

// File: tb/tb_multi_box_renderer.sv
// Self-checking bench for multi_box_renderer: directed frame updates plus
// randomized pixel probes against an integer model of the bouncing boxes.
module tb_multi_box_renderer;

  localparam int N  = 4;
  localparam int BW = 64;
  localparam int BH = 48;
  localparam int XL = 640 - BW;
  localparam int YL = 480 - BH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  multi_box_renderer_if vga();

  multi_box_renderer #(.N_BOXES(N)) dut (
    .clk(clk),
    .rst(rst),
    .vga(vga)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int mx [N];
  int my [N];
  int mxv[N];
  int myv[N];
  int mc [N];
  int overlap_checks = 0;
  int busy_cnt;

  // Model state evolves by the bouncing rules using plain integers.
  function automatic void modelReset();
    for (int i = 0; i < N; i++) begin
      mx[i]  = 20 + (130 * i) % 576;
      my[i]  = 10 + (90 * i) % 432;
      mxv[i] = (i % 2 == 0) ? (1 + i % 3) : -(1 + i % 3);
      myv[i] = (i % 2 == 0) ? 1 : -2;
      mc[i]  = 1 + i % 7;
    end
  endfunction

  function automatic void modelFrame();
    for (int i = 0; i < N; i++) begin
      int tx, ty;
      bit hx, hy;
      tx = mx[i] + mxv[i];
      ty = my[i] + myv[i];
      hx = (tx < 0) || (tx >= XL);
      hy = (ty < 0) || (ty >= YL);
      mx[i] = (tx < 0) ? 0 : (tx > XL ? XL : tx);
      my[i] = (ty < 0) ? 0 : (ty > YL ? YL : ty);
      if (hx) mxv[i] = -mxv[i];
      if (hy) myv[i] = -myv[i];
      if (hx || hy) mc[i] = (mc[i] % 7) + 1;
    end
  endfunction

  function automatic int modelColor(int px, int py);
    for (int i = 0; i < N; i++)
      if (px >= mx[i] && px < mx[i] + BW && py >= my[i] && py < my[i] + BH)
        return mc[i];
    return 0;
  endfunction

  task automatic checkOutput(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkBoxes(input string tag);
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("%s box%0d x", tag, i), int'($signed(dut.box_q[i].x)), mx[i]);
      checkOutput($sformatf("%s box%0d y", tag, i), int'($signed(dut.box_q[i].y)), my[i]);
      checkOutput($sformatf("%s box%0d xv", tag, i), int'($signed(dut.box_q[i].xv)), mxv[i]);
      checkOutput($sformatf("%s box%0d yv", tag, i), int'($signed(dut.box_q[i].yv)), myv[i]);
      checkOutput($sformatf("%s box%0d color", tag, i), int'(dut.box_q[i].color), mc[i]);
    end
  endtask

  task automatic applyStimulus(input int px, input int py, input bit vis);
    vga.position_x = 10'(px);
    vga.position_y = 9'(py);
    vga.visible    = vis;
    @(negedge clk);
  endtask

  task automatic checkPixel(input string tag, input int px, input int py, input bit vis);
    int c;
    applyStimulus(px, py, vis);
    c = vis ? modelColor(px, py) : 0;
    checkOutput({tag, " r"}, int'(vga.r), c[0] ? 15 : 0);
    checkOutput({tag, " g"}, int'(vga.g), c[1] ? 15 : 0);
    checkOutput({tag, " b"}, int'(vga.b), c[2] ? 15 : 0);
  endtask

  // One frame_tick pulse, then wait (bounded) for the update to finish.
  task automatic doTick();
    vga.frame_tick = 1'b1;
    @(negedge clk);
    vga.frame_tick = 1'b0;
    repeat (N + 1) @(negedge clk);
    for (int k = 0; k < 20 && vga.update_busy; k++) @(negedge clk);
    checkOutput("update finished", int'(vga.update_busy), 0);
    modelFrame();
  endtask

  initial begin
    vga.frame_tick = 1'b0;
    vga.visible    = 1'b0;
    vga.position_x = '0;
    vga.position_y = '0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    checkOutput("reset busy", int'(vga.update_busy), 0);
    checkOutput("reset r", int'(vga.r), 0);
    checkOutput("reset g", int'(vga.g), 0);
    checkOutput("reset b", int'(vga.b), 0);
    checkBoxes("reset");
    checkOutput("reset box2 x", int'($signed(dut.box_q[2].x)), 280);
    checkOutput("reset box3 y", int'($signed(dut.box_q[3].y)), 280);

    applyStimulus(20, 10, 1'b1);
    checkOutput("pixel(20,10) r", int'(vga.r), 15);
    checkOutput("pixel(20,10) g", int'(vga.g), 0);
    checkOutput("pixel(20,10) b", int'(vga.b), 0);
    checkPixel("pixel(83,57)", 83, 57, 1'b1);
    checkPixel("pixel(84,57)", 84, 57, 1'b1);
    vga.visible = 1'b0;

    // First frame: busy for exactly N cycles starting the cycle after the tick.
    vga.frame_tick = 1'b1;
    @(negedge clk);
    vga.frame_tick = 1'b0;
    checkOutput("busy after tick", int'(vga.update_busy), 1);
    busy_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (vga.update_busy) busy_cnt++;
      @(negedge clk);
    end
    checkOutput("busy cycle count", busy_cnt, N);
    modelFrame();
    checkBoxes("frame1");
    checkOutput("frame1 box0 x", int'($signed(dut.box_q[0].x)), 21);
    checkOutput("frame1 box1 y", int'($signed(dut.box_q[1].y)), 98);

    for (int t = 1; t < 556; t++) doTick();
    checkBoxes("frame556");
    checkOutput("frame556 box0 x", int'($signed(dut.box_q[0].x)), 576);
    checkOutput("frame556 box0 xv", int'($signed(dut.box_q[0].xv)), -1);
    doTick();
    checkOutput("frame557 box0 x", int'($signed(dut.box_q[0].x)), 575);
    checkBoxes("frame557");

    // A second tick while stepping must not cause extra steps.
    vga.frame_tick = 1'b1;
    @(negedge clk);
    vga.frame_tick = 1'b0;
    @(negedge clk);
    vga.frame_tick = 1'b1;
    @(negedge clk);
    vga.frame_tick = 1'b0;
    repeat (N + 4) @(negedge clk);
    modelFrame();
    checkOutput("retick idle", int'(vga.update_busy), 0);
    checkBoxes("retick");

    for (int t = 0; t < 300; t++) begin
      int nt;
      nt = int'($urandom_range(0, 3));
      for (int k = 0; k < nt; k++) doTick();
      for (int p = 0; p < 2; p++)
        checkPixel("random pixel", int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
                   bit'($urandom_range(0, 3) != 0));
      checkPixel("box1 pixel", mx[1] + int'($urandom_range(0, BW - 1)),
                 my[1] + int'($urandom_range(0, BH - 1)), 1'b1);
      begin
        int ox, oy;
        ox = (mx[0] > mx[1]) ? mx[0] : mx[1];
        oy = (my[0] > my[1]) ? my[0] : my[1];
        if (ox < mx[0] + BW && ox < mx[1] + BW && oy < my[0] + BH && oy < my[1] + BH) begin
          overlap_checks++;
          checkPixel("overlap visible", ox, oy, 1'b1);
          checkPixel("overlap hidden", ox, oy, 1'b0);
        end
      end
    end
    checkBoxes("random");
    $display("[TB] overlap probes: %0d", overlap_checks);

    // Reset in the middle of an update aborts it and reloads every box.
    vga.frame_tick = 1'b1;
    @(negedge clk);
    vga.frame_tick = 1'b0;
    @(negedge clk);
    checkOutput("midstep busy", int'(vga.update_busy), 1);
    rst = 1'b1;
    @(negedge clk);
    modelReset();
    checkOutput("midstep reset busy", int'(vga.update_busy), 0);
    checkBoxes("midstep reset");
    rst = 1'b0;
    repeat (N + 2) @(negedge clk);
    checkBoxes("after reset");
    checkPixel("after reset pixel", 150, 100, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
